// File: rtl/dffram_pin_ctrl.sv
// Byte-serial command controller for the DFFRAM macro.
// A header byte selects read or write, the auto-increment mode and the word
// address. Writes collect four bytes, least significant byte first. Reads
// fetch one word and return it as four bytes, least significant byte first.
// All outputs are registered: each register loads the value that belongs to
// the state being entered on that edge.
module dffram_pin_ctrl #(
  parameter int AW       = 5,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic          busy,
  output logic [7:0]    out_byte,
  output logic          out_valid,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDATA = 3'd1,
    WRITE = 3'd2,
    RREQ  = 3'd3,
    RWAIT = 3'd4,
    RDATA = 3'd5
  } state_t;

  // RWAIT leaves once this many extra cycles have gone by after RREQ.
  localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            ai_q, ai_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [1:0]      rcnt_q, rcnt_d;
  logic [31:0]     data_q, data_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            busy_d;
  logic [7:0]      out_byte_d;
  logic            out_valid_d;
  logic            ram_en_d;
  logic [3:0]      ram_we_d;
  logic [AW-1:0]   ram_addr_d;
  logic [31:0]     ram_di_d;

  // Auto-increment wraps naturally at 2^AW.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return a + AW'(1);
  endfunction

  // Only IDLE and WDATA can take a byte from the pins.
  function automatic logic is_busy(input state_t s);
    return (s != IDLE) && (s != WDATA);
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ai_d        = ai_q;
    bcnt_d      = bcnt_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'h0;
    ram_addr_d  = ram_addr;
    ram_di_d    = ram_di;
    out_valid_d = 1'b0;
    out_byte_d  = out_byte;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ai_d   = in_byte[6];
          addr_d = in_byte[AW-1:0];
          bcnt_d = 2'd0;
          if (in_byte[7]) begin
            state_d = WDATA;
          end else begin
            state_d    = RREQ;
            ram_en_d   = 1'b1;
            ram_addr_d = in_byte[AW-1:0];
          end
        end
      end

      WDATA: begin
        if (in_valid) begin
          data_d = {in_byte, data_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d    = WRITE;
            ram_en_d   = 1'b1;
            ram_we_d   = 4'hF;
            ram_addr_d = addr_q;
            ram_di_d   = data_d;
          end
        end
      end

      WRITE: begin
        bcnt_d = 2'd0;
        if (ai_q) begin
          addr_d  = addr_inc(addr_q);
          state_d = WDATA;
        end else begin
          state_d = IDLE;
        end
      end

      RREQ: begin
        wcnt_d  = 2'd0;
        state_d = RWAIT;
      end

      RWAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          rdata_d     = {8'h00, ram_do[31:8]};
          out_byte_d  = ram_do[7:0];
          out_valid_d = 1'b1;
          rcnt_d      = 2'd0;
          state_d     = RDATA;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end

      RDATA: begin
        if (rcnt_q == 2'd3) begin
          if (ai_q) begin
            addr_d     = addr_inc(addr_q);
            ram_addr_d = addr_inc(addr_q);
            ram_en_d   = 1'b1;
            state_d    = RREQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rcnt_d      = rcnt_q + 2'd1;
          out_byte_d  = rdata_q[7:0];
          rdata_d     = {8'h00, rdata_q[31:8]};
          out_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Deselecting the tile aborts whatever is in flight, including a
    // half-collected write, and kills all strobes from this edge on.
    if (!ena) begin
      state_d     = IDLE;
      bcnt_d      = 2'd0;
      ram_en_d    = 1'b0;
      ram_we_d    = 4'h0;
      out_valid_d = 1'b0;
    end

    busy_d = is_busy(state_d);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      ai_q      <= 1'b0;
      bcnt_q    <= 2'd0;
      wcnt_q    <= 2'd0;
      rcnt_q    <= 2'd0;
      data_q    <= '0;
      rdata_q   <= '0;
      busy      <= 1'b0;
      out_byte  <= 8'h00;
      out_valid <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 4'h0;
      ram_addr  <= '0;
      ram_di    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ai_q      <= ai_d;
      bcnt_q    <= bcnt_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      busy      <= busy_d;
      out_byte  <= out_byte_d;
      out_valid <= out_valid_d;
      ram_en    <= ram_en_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_di    <= ram_di_d;
    end
  end

endmodule
